// File: rtl/hvtx_pkg.sv
// Shared types and colour constants for the HDMI TX video-source stages.
// Pixel colours are carried as {r, g, b} with red in the most significant byte.
package hvtx_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam rgb_t COLOR_BLACK   = 24'h000000;
  localparam rgb_t COLOR_MAGENTA = 24'hff00a8;

endpackage

// File: rtl/hvtx_bounce_axis.sv
// One axis of the bouncing sprite: a position that walks between 0 and LIMIT,
// clamping onto the wall and reversing direction when a step would overshoot.
module hvtx_bounce_axis
  import hvtx_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int LIMIT = 1270,
  parameter int STEP  = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_move,
  output logic [WIDTH-1:0] o_pos,
  output dir_e             o_dir
);

  if (LIMIT < 0 || LIMIT >= 2**WIDTH) begin : g_bad_limit
    $fatal(1, "hvtx_bounce_axis: LIMIT does not fit in WIDTH bits");
  end
  if (STEP < 1 || STEP > LIMIT) begin : g_bad_step
    $fatal(1, "hvtx_bounce_axis: STEP must be in 1..LIMIT");
  end

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   LIMIT_E = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0]   STEP_E  = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] pos_q;
  logic [WIDTH-1:0] pos_d;
  dir_e             dir_q;
  dir_e             dir_d;
  logic [WIDTH:0]   fwd_sum;
  logic             hit_fwd;
  logic             hit_rev;

  // One extra bit keeps pos+STEP from wrapping near the top of the range.
  assign fwd_sum = {1'b0, pos_q} + STEP_E;
  assign hit_fwd = (fwd_sum >= LIMIT_E);
  assign hit_rev = ({1'b0, pos_q} <= STEP_E);

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (dir_q == DIR_FWD) begin
      if (hit_fwd) begin
        pos_d = LIMIT_W;
        dir_d = DIR_REV;
      end else begin
        pos_d = fwd_sum[WIDTH-1:0];
      end
    end else begin
      if (hit_rev) begin
        pos_d = '0;
        dir_d = DIR_FWD;
      end else begin
        pos_d = pos_q - STEP_W;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q <= '0;
      dir_q <= DIR_FWD;
    end else if (i_move) begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign o_pos = pos_q;
  assign o_dir = dir_q;

endmodule

// File: rtl/hvtx_box_anim.sv
// Video source for the HDMI TX path: draws a solid square sprite over a flat
// background and bounces it diagonally, moving only between frames.
module hvtx_box_anim
  import hvtx_pkg::*;
#(
  parameter int   WIDTH           = 11,
  parameter int   ACTIVE_WIDTH    = 1280,
  parameter int   ACTIVE_HEIGHT   = 720,
  parameter int   BOX_SIZE        = 10,
  parameter int   STEP            = 10,
  parameter int   FRAMES_PER_MOVE = 1,
  parameter rgb_t FG_COLOR        = COLOR_MAGENTA,
  parameter rgb_t BG_COLOR        = COLOR_BLACK
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_en,
  output logic [23:0]      o_video,
  output logic             o_frame_tick,
  output logic [WIDTH-1:0] o_box_x,
  output logic [WIDTH-1:0] o_box_y
);

  localparam int MAX_X = ACTIVE_WIDTH - BOX_SIZE;
  localparam int MAX_Y = ACTIVE_HEIGHT - BOX_SIZE;
  localparam int DIV_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

  if (BOX_SIZE > ACTIVE_WIDTH || BOX_SIZE > ACTIVE_HEIGHT) begin : g_bad_box
    $fatal(1, "hvtx_box_anim: BOX_SIZE larger than the active area");
  end
  if (STEP < 1 || STEP > MAX_X || STEP > MAX_Y) begin : g_bad_step
    $fatal(1, "hvtx_box_anim: STEP must be in 1..MAX of each axis");
  end
  if (FRAMES_PER_MOVE < 1) begin : g_bad_div
    $fatal(1, "hvtx_box_anim: FRAMES_PER_MOVE must be at least 1");
  end
  if (ACTIVE_WIDTH >= 2**WIDTH || ACTIVE_HEIGHT >= 2**WIDTH) begin : g_bad_width
    $fatal(1, "hvtx_box_anim: active area does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] ACT_W   = WIDTH'(ACTIVE_WIDTH);
  localparam logic [WIDTH-1:0] ACT_H   = WIDTH'(ACTIVE_HEIGHT);
  localparam logic [WIDTH:0]   BOX_E   = (WIDTH+1)'(BOX_SIZE);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(FRAMES_PER_MOVE - 1);

  logic [WIDTH-1:0] box_x;
  logic [WIDTH-1:0] box_y;
  dir_e             dir_x;
  dir_e             dir_y;
  logic             unused_dir;
  logic             tick_q;
  logic             at_frame_end;
  logic [DIV_W-1:0] div_q;
  logic             div_wrap;
  logic             move;
  logic [WIDTH:0]   x_e;
  logic [WIDTH:0]   y_e;
  logic [WIDTH:0]   bx_e;
  logic [WIDTH:0]   by_e;
  logic             in_box;
  logic             in_active;
  rgb_t             pixel_d;
  rgb_t             video_q;

  // The tick is raised on the first blanking pixel after the last active line,
  // so any move it triggers lands well before the next frame's active area.
  assign at_frame_end = (i_x == ACT_W) && (i_y == ACT_H);
  assign div_wrap     = (div_q == DIV_TOP);
  assign move         = tick_q && i_en && div_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q <= '0;
    end else if (tick_q && i_en) begin
      div_q <= div_wrap ? '0 : div_q + 1'b1;
    end
  end

  hvtx_bounce_axis #(
    .WIDTH (WIDTH),
    .LIMIT (MAX_X),
    .STEP  (STEP)
  ) u_axis_x (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_move  (move),
    .o_pos   (box_x),
    .o_dir   (dir_x)
  );

  hvtx_bounce_axis #(
    .WIDTH (WIDTH),
    .LIMIT (MAX_Y),
    .STEP  (STEP)
  ) u_axis_y (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_move  (move),
    .o_pos   (box_y),
    .o_dir   (dir_y)
  );

  // Direction is internal bookkeeping of the axes; nothing downstream needs it.
  assign unused_dir = ^{dir_x, dir_y};

  assign x_e  = {1'b0, i_x};
  assign y_e  = {1'b0, i_y};
  assign bx_e = {1'b0, box_x};
  assign by_e = {1'b0, box_y};

  assign in_box = (x_e >= bx_e) && (x_e < bx_e + BOX_E) &&
                  (y_e >= by_e) && (y_e < by_e + BOX_E);
  assign in_active = (i_x < ACT_W) && (i_y < ACT_H);

  always_comb begin
    pixel_d = COLOR_BLACK;
    if (in_box) begin
      pixel_d = FG_COLOR;
    end else if (in_active) begin
      pixel_d = BG_COLOR;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      video_q <= COLOR_BLACK;
      tick_q  <= 1'b0;
    end else begin
      video_q <= pixel_d;
      tick_q  <= at_frame_end;
    end
  end

  assign o_video      = video_q;
  assign o_frame_tick = tick_q;
  assign o_box_x      = box_x;
  assign o_box_y      = box_y;

endmodule

// File: doc/hvtx_box_anim.md
Name: hvtx_box_anim

Overview:
- Upstream video-source stage for the HDMI TX path. Consumes the pixel cursor (x, y) and produces the 24-bit RGB pixel fed to hvtx_mod.
- Renders a solid square sprite that bounces diagonally inside the active area. Position advances once per N frames, and updates only during blanking.
- Replaces the ad-hoc inline box logic in the top level with a parameterised, reset-clean, tested block.

Parameters:
- WIDTH, 11: width of cursor and position values.
- ACTIVE_WIDTH, 1280: active pixels per line.
- ACTIVE_HEIGHT, 720: active lines per frame.
- BOX_SIZE, 10: sprite edge length in pixels.
- STEP, 10: pixels moved per axis per move event.
- FRAMES_PER_MOVE, 1: frame ticks between move events (>=1).
- FG_COLOR, 24'hff00a8: sprite RGB.
- BG_COLOR, 24'h000000: background RGB inside the active area.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_x  in  WIDTH  cursor column, from hvtx_cursor.
- i_y  in  WIDTH  cursor row, from hvtx_cursor.
- i_en  in  1  animation enable. When low, position and frame divider freeze; drawing continues.
- o_video  out  24  RGB pixel, registered.
- o_frame_tick  out  1  one-cycle pulse at end of active frame.
- o_box_x  out  WIDTH  current sprite left edge.
- o_box_y  out  WIDTH  current sprite top edge.

Behaviour:
- Reset (async assert, sync release by i_clk):
  - o_video = 0, o_frame_tick = 0.
  - o_box_x = 0, o_box_y = 0.
  - dir_x = RIGHT, dir_y = DOWN.
  - Frame divider = 0.
  - Assertion mid-frame clears all state immediately, with no clock edge required.
- Drawing, 1-cycle latency:
  - o_video <= FG_COLOR when i_x in [box_x, box_x+BOX_SIZE) and i_y in [box_y, box_y+BOX_SIZE).
  - Otherwise BG_COLOR when i_x < ACTIVE_WIDTH and i_y < ACTIVE_HEIGHT.
  - Otherwise 0 (blanking).
  - Comparisons use WIDTH+1 bits so box_x+BOX_SIZE cannot wrap.
- Frame tick:
  - Registered one-cycle pulse, asserted the cycle after the cursor equals (ACTIVE_WIDTH, ACTIVE_HEIGHT), i.e. the first pixel after the active area.
  - Independent of i_en.
- Frame divider:
  - On each tick with i_en=1: if divider == FRAMES_PER_MOVE-1, divider <= 0 and a move event fires; else divider increments.
  - With i_en=0 the divider holds.
- Move event, per axis independently, with MAX = ACTIVE_dim - BOX_SIZE:
  - Forward direction (RIGHT/DOWN): if pos+STEP >= MAX, then pos <= MAX and direction flips; else pos <= pos+STEP.
  - Reverse direction (LEFT/UP): if pos <= STEP, then pos <= 0 and direction flips; else pos <= pos-STEP.
  - Both axes may flip on the same event (corner hit). No special case is applied.
- Position registers update only on the move event, which always occurs in vertical blanking. The sprite therefore never tears within a frame.
- o_box_x and o_box_y are the registered positions themselves.
- Elaboration checks (fatal):
  - BOX_SIZE <= ACTIVE_WIDTH and BOX_SIZE <= ACTIVE_HEIGHT.
  - 0 < STEP <= MAX of each axis.
  - FRAMES_PER_MOVE >= 1.
  - ACTIVE_WIDTH and ACTIVE_HEIGHT < 2**WIDTH.

Decomposition:
- hvtx_pkg holds:
  - rgb_t, a 24-bit packed struct {r, g, b}.
  - dir_e enum {DIR_FWD, DIR_REV}.
  - Colour constants COLOR_BLACK and COLOR_MAGENTA (24'hff00a8).
- Sub-module hvtx_bounce_axis (instanced twice, x and y):
  - Parameters WIDTH, LIMIT, STEP.
  - Ports i_clk, i_rst_n, i_move, o_pos, o_dir.
  - Owns position/direction registers and the clamp/flip rule.
- hvtx_box_anim owns the tick detection, the frame divider and the pixel compare/colour mux.

Test Plan:
- Reset release, defaults, cursor (0,0)..(9,9) -> o_video = ff00a8 one cycle after each cursor value; (10,0) -> 000000; (1300,5) -> 000000; o_box_x = o_box_y = 0.
- Cursor reaches (1280,720) -> o_frame_tick high exactly one cycle; box moves (0,0) -> (10,10); next full frame renders the sprite at (10..19, 10..19) with no change during active lines.
- Preload via 126 move events so box_x = 1260, RIGHT -> next event gives box_x = 1270 and dir LEFT -> following event gives 1260. Y axis flips at 710 the same way; a corner hit flips both axes on one event.
- STEP = 7, box_x = 1265, RIGHT -> box_x = 1270 (clamped), dir LEFT. LEFT from box_x = 5 -> box_x = 0, dir RIGHT.
- FRAMES_PER_MOVE = 3 -> box moves only on ticks 3, 6, 9. With i_en = 0 for ticks 4-8, ticks still pulse but position and divider hold; movement resumes on the 3rd enabled tick after i_en returns high.
- Drive i_rst_n low mid-active-line between clock edges -> o_video, o_box_x/y and o_frame_tick go to 0 before the next i_clk edge. Release -> first frame tick moves the box to (10,10).
